// File: rtl/uart_frame_pkg.sv
// Shared definitions for the AAP host-link UART frame sequencers.
package uart_frame_pkg;

    localparam logic [7:0] SOF              = 8'hA5;
    localparam int         DEF_MAX_LEN      = 16;
    localparam int         DEF_TIMEOUT_CLKS = 2048;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_HOLD
    } state_t;

    // One-hot error pulse bundle; at most one bit is set in any cycle.
    typedef struct packed {
        logic csum;
        logic len;
        logic timeout;
        logic overrun;
    } err_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Loadable up-counter with synchronous clear, count enable and a
// terminal-count flag against a run-time terminal value.
module uart_frame_timeout #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Clear beats load beats count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART receive byte stream (SOF CMD LEN payload CSUM) into
// checked debug commands for the AAP command decoder.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
    parameter int LEN_W        = $clog2(MAX_LEN + 1),
    parameter int ADDR_W       = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [7:0]        frm_cmd,
    output logic [LEN_W-1:0]  frm_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              err_csum,
    output logic              err_len,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic              busy
);

    localparam int         TO_W      = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t                   state;
    err_t                     err_q;
    logic [7:0]               acc;
    logic [LEN_W-1:0]         idx;
    logic [MAX_LEN-1:0][7:0]  pay_buf;
    logic                     active;
    logic                     to_tc;
    logic                     to_fire;
    logic                     buf_we;

    assign active  = (state == ST_CMD) || (state == ST_LEN) ||
                     (state == ST_PAYLOAD) || (state == ST_CSUM);
    // Counter is loaded with 1 on each byte, so it holds the clocks elapsed
    // since that byte; firing one short of TIMEOUT_CLKS-1 lands the pulse
    // TIMEOUT_CLKS-1 clocks after the strobe. A byte that cycle wins.
    assign to_fire = active && !rx_valid && to_tc;
    assign buf_we  = (state == ST_PAYLOAD) && rx_valid;

    uart_frame_timeout #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (to_fire),
        .load     (rx_valid),
        .load_val (TO_W'(1)),
        .en       (active),
        .term     (TO_W'(TIMEOUT_CLKS - 2)),
        .tc       (to_tc)
    );

    // Frame parser: state, header latches, running checksum and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            frm_valid <= 1'b0;
            frm_cmd   <= '0;
            frm_len   <= '0;
            acc       <= '0;
            idx       <= '0;
            err_q     <= '0;
        end else begin
            err_q <= '0;
            if (to_fire) begin
                err_q.timeout <= 1'b1;
                state         <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (rx_valid && rx_data == SOF) begin
                        acc   <= '0;
                        state <= ST_CMD;
                    end
                    ST_CMD: if (rx_valid) begin
                        frm_cmd <= rx_data;
                        acc     <= acc + rx_data;
                        state   <= ST_LEN;
                    end
                    ST_LEN: if (rx_valid) begin
                        acc <= acc + rx_data;
                        if (rx_data > MAX_LEN_B) begin
                            err_q.len <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            frm_len <= rx_data[LEN_W-1:0];
                            idx     <= '0;
                            state   <= (rx_data == 8'h00) ? ST_CSUM : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: if (rx_valid) begin
                        acc <= acc + rx_data;
                        idx <= idx + 1'b1;
                        if (idx + 1'b1 == frm_len) state <= ST_CSUM;
                    end
                    ST_CSUM: if (rx_valid) begin
                        if (8'(acc + rx_data) == 8'h00) begin
                            frm_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            err_q.csum <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (frm_ready) begin
                            // Handshake frees the buffer; a coincident byte
                            // is parsed as if we were already idle.
                            frm_valid <= 1'b0;
                            if (rx_valid && rx_data == SOF) begin
                                acc   <= '0;
                                state <= ST_CMD;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else if (rx_valid) begin
                            err_q.overrun <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Payload store; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (buf_we) pay_buf[idx[ADDR_W-1:0]] <= rx_data;
    end

    assign rd_data     = ({1'b0, rd_addr} < (ADDR_W+1)'(MAX_LEN)) ? pay_buf[rd_addr] : 8'h00;
    assign err_csum    = err_q.csum;
    assign err_len     = err_q.len;
    assign err_timeout = err_q.timeout;
    assign err_overrun = err_q.overrun;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomised + directed bench for uart_rx_frame_ctrl with a frame-level model.
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TO      = 2048;
    localparam int LEN_W   = 5;
    localparam int ADDR_W  = 4;

    logic              clk, rst;
    logic              rx_valid, frm_ready;
    logic [7:0]        rx_data;
    logic              frm_valid;
    logic [7:0]        frm_cmd;
    logic [LEN_W-1:0]  frm_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              err_csum, err_len, err_timeout, err_overrun, busy;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_cmd(frm_cmd),
        .frm_len(frm_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- behavioural model: bytes collected after SOF, judged by position ----
    logic [7:0] m_q[$];
    bit         m_in, m_hold;
    int         m_silent;
    logic [7:0] m_cmd;
    int         m_len;
    logic [7:0] m_pay[MAX_LEN];
    bit         e_csum, e_len, e_to, e_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in = 0; m_hold = 0; m_silent = 0;
        e_csum = 0; e_len = 0; e_to = 0; e_ovr = 0;
    endtask

    // Expected outputs after the coming clock edge, given this cycle's inputs.
    task automatic model_step(input bit v, input logic [7:0] d, input bit rdy);
        bit idle_byte;
        int sum;
        idle_byte = 0;
        e_csum = 0; e_len = 0; e_to = 0; e_ovr = 0;
        if (m_hold) begin
            if (rdy) begin m_hold = 0; idle_byte = v; end
            else if (v) e_ovr = 1;
        end else if (m_in) begin
            if (v) begin
                m_silent = 0;
                m_q.push_back(d);
                if (m_q.size() == 2 && int'(m_q[1]) > MAX_LEN) begin
                    e_len = 1; m_in = 0;
                end else if (m_q.size() >= 2 && m_q.size() == int'(m_q[1]) + 3) begin
                    sum = 0;
                    foreach (m_q[i]) sum += int'(m_q[i]);
                    if (sum % 256 == 0) begin
                        m_hold = 1; m_cmd = m_q[0]; m_len = int'(m_q[1]);
                        for (int i = 0; i < m_len; i++) m_pay[i] = m_q[i+2];
                    end else e_csum = 1;
                    m_in = 0;
                end
            end else begin
                // Pulse must land TIMEOUT_CLKS-1 clocks after the last strobe;
                // the strobe edge itself accounts for one of those clocks.
                m_silent++;
                if (m_silent == TO - 2) begin e_to = 1; m_in = 0; end
            end
        end else idle_byte = v;
        if (idle_byte && d == 8'hA5) begin m_in = 1; m_q.delete(); m_silent = 0; end
    endtask

    task automatic check_outputs();
        chk("frm_valid", 32'(frm_valid), 32'(m_hold));
        chk("busy", 32'(busy), 32'(m_in | m_hold));
        chk("err_csum", 32'(err_csum), 32'(e_csum));
        chk("err_len", 32'(err_len), 32'(e_len));
        chk("err_timeout", 32'(err_timeout), 32'(e_to));
        chk("err_overrun", 32'(err_overrun), 32'(e_ovr));
        if (m_hold) begin
            chk("frm_cmd", 32'(frm_cmd), 32'(m_cmd));
            chk("frm_len", 32'(frm_len), 32'(m_len));
            if (int'(rd_addr) < m_len) chk("rd_data", 32'(rd_data), 32'(m_pay[rd_addr]));
        end
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic tick(input bit v, input logic [7:0] d, input bit rdy);
        rx_valid = v; rx_data = d; frm_ready = rdy;
        rd_addr = ADDR_W'($urandom);
        model_step(v, d, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_d(input logic [7:0] d);
        tick(1'b1, d, 1'b0);
    endtask

    task automatic peek(input string name, input int a, input logic [7:0] exp);
        rd_addr = ADDR_W'(a);
        #1;
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    // Random byte with a short random gap and random ready.
    task automatic send_r(input logic [7:0] d);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick(1'b0, 8'h00, ($urandom % 3) == 0);
        tick(1'b1, d, ($urandom % 3) == 0);
    endtask

    task automatic rand_frame(input int kind);
        logic [7:0] cmd, len, s;
        cmd = 8'($urandom);
        case (kind)
            0, 1: begin
                len = 8'($urandom_range(0, MAX_LEN));
                s = cmd + len;
                send_r(8'hA5); send_r(cmd); send_r(len);
                for (int i = 0; i < int'(len); i++) begin
                    logic [7:0] p;
                    p = 8'($urandom);
                    s += p;
                    send_r(p);
                end
                if (kind == 0) send_r(8'h00 - s);
                else send_r(8'h00 - s + 8'($urandom_range(1, 255)));
            end
            2: begin
                send_r(8'hA5); send_r(cmd); send_r(8'($urandom_range(MAX_LEN + 1, 255)));
            end
            default: send_r(8'($urandom));
        endcase
    endtask

    initial begin
        bit seen;
        rst = 1'b1; rx_valid = 0; rx_data = 0; frm_ready = 0; rd_addr = 0;
        model_reset();
        #1;
        chk("rst_frm_valid", 32'(frm_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_errs", 32'({err_csum, err_len, err_timeout, err_overrun}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Leading garbage, then a 3-byte frame: 10+03+11+22+33 = 0x79, CSUM 0x87.
        send_d(8'h00); send_d(8'hFF); send_d(8'h55);
        send_d(8'hA5); send_d(8'h10); send_d(8'h03);
        send_d(8'h11); send_d(8'h22); send_d(8'h33); send_d(8'h87);
        chk("f1_valid", 32'(frm_valid), 1);
        chk("f1_cmd", 32'(frm_cmd), 32'h10);
        chk("f1_len", 32'(frm_len), 3);
        peek("f1_rd0", 0, 8'h11); peek("f1_rd1", 1, 8'h22); peek("f1_rd2", 2, 8'h33);
        // Byte while held -> overrun, frame untouched.
        send_d(8'h77);
        chk("ovr_pulse", 32'(err_overrun), 1);
        chk("ovr_cmd", 32'(frm_cmd), 32'h10);
        peek("ovr_rd1", 1, 8'h22);
        // Ready coincident with SOF: frame released, new frame started.
        tick(1'b1, 8'hA5, 1'b1);
        chk("rdy_sof_valid", 32'(frm_valid), 0);
        chk("rdy_sof_busy", 32'(busy), 1);
        send_d(8'h20); send_d(8'h00); send_d(8'hE0);
        chk("zl_valid", 32'(frm_valid), 1);
        chk("zl_len", 32'(frm_len), 0);
        tick(1'b0, 8'h00, 1'b1);
        chk("zl_release_busy", 32'(busy), 0);
        // Zero-length with bad CSUM.
        send_d(8'hA5); send_d(8'h20); send_d(8'h00); send_d(8'hE1);
        chk("bad_csum", 32'(err_csum), 1);
        // Over-long LEN, then a good frame.
        send_d(8'hA5); send_d(8'h01); send_d(8'h11);
        chk("bad_len", 32'(err_len), 1);
        send_d(8'hA5); send_d(8'h02); send_d(8'h00); send_d(8'hFE);
        chk("after_len_valid", 32'(frm_valid), 1);
        tick(1'b0, 8'h00, 1'b1);

        // Inter-byte timeout latency.
        send_d(8'hA5); send_d(8'h10);
        seen = 0;
        for (int j = 1; j <= TO + 50 && !seen; j++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (err_timeout) begin
                seen = 1;
                chk("to_latency", 32'(j + 1), 32'(TO - 1));
                chk("to_busy", 32'(busy), 0);
            end
        end
        if (!seen) chk("to_seen", 0, 1);
        // Byte in the last allowed cycle keeps the frame alive.
        send_d(8'hA5); send_d(8'h10);
        repeat (TO - 3) tick(1'b0, 8'h00, 1'b0);
        send_d(8'h00); send_d(8'hF0);
        chk("to_edge_valid", 32'(frm_valid), 1);
        tick(1'b0, 8'h00, 1'b1);

        // Reset in PAYLOAD.
        send_d(8'hA5); send_d(8'h10); send_d(8'h05); send_d(8'h11); send_d(8'h22);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_outs", 32'({frm_valid, frm_cmd, 3'(frm_len)}), 0);
        chk("midrst_errs", 32'({err_csum, err_len, err_timeout, err_overrun}), 0);
        model_reset();
        rx_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        // 30+02+AB+CD = 0x1AA -> CSUM 0x56.
        send_d(8'hA5); send_d(8'h30); send_d(8'h02); send_d(8'hAB); send_d(8'hCD); send_d(8'h56);
        chk("postrst_cmd", 32'(frm_cmd), 32'h30);
        chk("postrst_len", 32'(frm_len), 2);
        peek("postrst_rd0", 0, 8'hAB); peek("postrst_rd1", 1, 8'hCD);
        tick(1'b0, 8'h00, 1'b1);

        // Random traffic: valid, bad csum, bad len, garbage, with random
        // ready so bytes also land during HOLD.
        for (int f = 0; f < 300; f++) rand_frame($urandom_range(0, 4) == 0 ? 3 : $urandom_range(0, 2));
        // A couple of mid-frame stalls.
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 8'h00, 1'b1);
            send_d(8'hA5); send_d(8'($urandom));
            repeat (TO) tick(1'b0, 8'h00, 1'b0);
        end
        repeat (8) tick(1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
